// File: rtl/superalu_share_arbiter.sv
// Two-port round-robin arbiter in front of a shared multi-cycle ALU.
// Latches the winner's operands, starts the ALU, waits (with timeout) and returns the result.
module superalu_share_arbiter #(
   parameter int DATA_WIDTH  = 16,
   parameter int OP_WIDTH    = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  req0_i,
   input  logic                  req1_i,
   input  logic [OP_WIDTH-1:0]   op0_i,
   input  logic [OP_WIDTH-1:0]   op1_i,
   input  logic [DATA_WIDTH-1:0] a0_i,
   input  logic [DATA_WIDTH-1:0] b0_i,
   input  logic [DATA_WIDTH-1:0] a1_i,
   input  logic [DATA_WIDTH-1:0] b1_i,
   output logic                  gnt0_o,
   output logic                  gnt1_o,
   output logic                  done0_o,
   output logic                  done1_o,
   output logic                  err0_o,
   output logic                  err1_o,
   output logic [DATA_WIDTH-1:0] res0_o,
   output logic [DATA_WIDTH-1:0] res1_o,
   output logic [DATA_WIDTH-1:0] rem0_o,
   output logic [DATA_WIDTH-1:0] rem1_o,
   output logic                  busy_o,
   output logic                  alu_start_o,
   output logic [OP_WIDTH-1:0]   alu_op_o,
   output logic [DATA_WIDTH-1:0] alu_a_o,
   output logic [DATA_WIDTH-1:0] alu_b_o,
   input  logic                  alu_done_i,
   input  logic [DATA_WIDTH-1:0] alu_res_i,
   input  logic [DATA_WIDTH-1:0] alu_rem_i
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

   state_e                state_q, state_d;
   logic                  last_q, last_d;
   logic                  win_q, win_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [1:0]            gnt_q, gnt_d;
   logic [1:0]            done_q, done_d;
   logic [1:0]            err_q, err_d;
   logic                  start_q, start_d;
   logic [OP_WIDTH-1:0]   op_q, op_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [DATA_WIDTH-1:0] res0_q, res0_d, rem0_q, rem0_d;
   logic [DATA_WIDTH-1:0] res1_q, res1_d, rem1_q, rem1_d;
   logic                  pick1;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      gnt_d   = '0;
      done_d  = '0;
      start_d = 1'b0;
      err_d   = err_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      res0_d  = res0_q;
      rem0_d  = rem0_q;
      res1_d  = res1_q;
      rem1_d  = rem1_q;
      // On a tie the port that was not granted last time wins.
      pick1   = req1_i & (~req0_i | ~last_q);
      case (state_q)
         IDLE: begin
            if (req0_i | req1_i) begin
               state_d      = ISSUE;
               win_d        = pick1;
               last_d       = pick1;
               gnt_d        = pick1 ? 2'b10 : 2'b01;
               start_d      = 1'b1;
               err_d[pick1] = 1'b0;
               op_d         = pick1 ? op1_i : op0_i;
               a_d          = pick1 ? a1_i : a0_i;
               b_d          = pick1 ? b1_i : b0_i;
            end
         end
         ISSUE: begin
            state_d = WAIT;
            cnt_d   = '0;
         end
         WAIT: begin
            // A done arriving on the timeout edge still delivers its result.
            if (alu_done_i) begin
               if (win_q) begin
                  res1_d = alu_res_i;
                  rem1_d = alu_rem_i;
               end else begin
                  res0_d = alu_res_i;
                  rem0_d = alu_rem_i;
               end
               done_d[win_q] = 1'b1;
               state_d       = RESP;
            end else if (cnt_q == TMO) begin
               if (win_q) begin
                  res1_d = '0;
                  rem1_d = '0;
               end else begin
                  res0_d = '0;
                  rem0_d = '0;
               end
               err_d[win_q]  = 1'b1;
               done_d[win_q] = 1'b1;
               state_d       = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         win_q   <= 1'b0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         err_q   <= '0;
         start_q <= 1'b0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res0_q  <= '0;
         rem0_q  <= '0;
         res1_q  <= '0;
         rem1_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         start_q <= start_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res0_q  <= res0_d;
         rem0_q  <= rem0_d;
         res1_q  <= res1_d;
         rem1_q  <= rem1_d;
      end
   end

   assign gnt0_o      = gnt_q[0];
   assign gnt1_o      = gnt_q[1];
   assign done0_o     = done_q[0];
   assign done1_o     = done_q[1];
   assign err0_o      = err_q[0];
   assign err1_o      = err_q[1];
   assign res0_o      = res0_q;
   assign rem0_o      = rem0_q;
   assign res1_o      = res1_q;
   assign rem1_o      = rem1_q;
   assign busy_o      = (state_q != IDLE);
   assign alu_start_o = start_q;
   assign alu_op_o    = op_q;
   assign alu_a_o     = a_q;
   assign alu_b_o     = b_q;

endmodule

// File: tb/tb_superalu_share_arbiter.sv
// Bench for superalu_share_arbiter: directed scenarios plus random traffic,
// all outputs compared every cycle against a timestamp-based transaction model.
module tb_superalu_share_arbiter;
   localparam int DW  = 16;
   localparam int OW  = 2;
   localparam int TMO = 10;

   logic clk;
   logic rst_n;
   logic req0, req1;
   logic [OW-1:0] op0, op1;
   logic [DW-1:0] a0, b0, a1, b1;
   logic gnt0, gnt1, done0, done1, err0, err1;
   logic [DW-1:0] res0, res1, rem0, rem1;
   logic busy, alu_start;
   logic [OW-1:0] alu_op;
   logic [DW-1:0] alu_a, alu_b;
   logic alu_done_m = 1'b0;
   logic stray;
   logic alu_done;
   logic [DW-1:0] alu_res = '0;
   logic [DW-1:0] alu_rem = '0;
   assign alu_done = alu_done_m | stray;

   int n_cmp = 0;
   int n_bad = 0;
   int n_start = 0;
   int n_gnt0 = 0;
   int alu_lat = 4;
   int cd = 0;
   bit chk_en = 1'b0;

   superalu_share_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .TIMEOUT_CYC(TMO)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req0_i(req0), .req1_i(req1), .op0_i(op0), .op1_i(op1),
      .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
      .gnt0_o(gnt0), .gnt1_o(gnt1), .done0_o(done0), .done1_o(done1),
      .err0_o(err0), .err1_o(err1), .res0_o(res0), .res1_o(res1),
      .rem0_o(rem0), .rem1_o(rem1), .busy_o(busy),
      .alu_start_o(alu_start), .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
      .alu_done_i(alu_done), .alu_res_i(alu_res), .alu_rem_i(alu_rem)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic alu_calc(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           output logic [DW-1:0] r, output logic [DW-1:0] m);
      logic [2*DW-1:0] p;
      int s;
      case (op)
         2'd0: begin p = 32'(a) * 32'(b); r = p[DW-1:0]; m = p[2*DW-1:DW]; end
         2'd1: if (b == '0) begin r = '1; m = a; end else begin r = a / b; m = a % b; end
         2'd2: begin
            s = 0;
            for (int i = 0; i < 256; i++) if (i * i <= int'(a)) s = i;
            r = DW'(s);
            m = a - DW'(s * s);
         end
         default: begin r = a + b; m = a ^ b; end
      endcase
   endtask

   // Shared ALU stand-in: latency 1..12 cycles, 13 (or <0) means it never answers.
   always @(negedge clk) begin : alu_model
      int l;
      logic [DW-1:0] r, m;
      alu_done_m = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) alu_done_m = 1'b1;
      end
      if (gnt0) n_gnt0++;
      if (alu_start) begin
         n_start++;
         alu_calc(alu_op, alu_a, alu_b, r, m);
         alu_res = r;
         alu_rem = m;
         l = (alu_lat == 0) ? int'($urandom_range(1, 13)) : alu_lat;
         cd = (l > 12 || l < 0) ? 0 : l;
      end
   end

   // Reference model: tracks the current transaction by the edge numbers of its grant and done.
   int cyc = 0;
   int m_g = 0;
   int m_d = -100;
   bit m_act = 1'b0;
   bit m_w = 1'b0;
   bit m_last = 1'b1;
   logic [1:0] m_gnt = '0, m_done = '0, m_err = '0;
   logic m_start = 1'b0, m_busy = 1'b0;
   logic [OW-1:0] m_op = '0;
   logic [DW-1:0] m_a = '0, m_b = '0;
   logic [DW-1:0] m_res[2];
   logic [DW-1:0] m_rem[2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0; m_act = 1'b0; m_last = 1'b1; m_d = -100; m_g = 0;
         m_gnt = '0; m_start = 1'b0; m_done = '0; m_err = '0; m_busy = 1'b0;
         m_op = '0; m_a = '0; m_b = '0;
         for (int i = 0; i < 2; i++) begin m_res[i] = '0; m_rem[i] = '0; end
      end else begin
         cyc++;
         m_gnt = '0; m_start = 1'b0; m_done = '0;
         if (m_act) begin
            if (cyc >= m_g + 2 && alu_done) begin
               m_res[m_w] = alu_res; m_rem[m_w] = alu_rem;
               m_done[m_w] = 1'b1; m_d = cyc; m_act = 1'b0;
            end else if (cyc == m_g + 2 + TMO) begin
               m_res[m_w] = '0; m_rem[m_w] = '0; m_err[m_w] = 1'b1;
               m_done[m_w] = 1'b1; m_d = cyc; m_act = 1'b0;
            end
         end else if (cyc >= m_d + 2 && (req0 || req1)) begin
            m_w = (req0 && req1) ? !m_last : req1;
            m_last = m_w; m_g = cyc; m_act = 1'b1;
            m_gnt[m_w] = 1'b1; m_start = 1'b1; m_err[m_w] = 1'b0;
            m_op = m_w ? op1 : op0;
            m_a  = m_w ? a1 : a0;
            m_b  = m_w ? b1 : b0;
         end
         m_busy = m_act || (cyc == m_d);
      end
   end

   always begin
      @(negedge clk);
      #1;
      if (chk_en) begin
         chk("gnt",       32'({gnt1, gnt0}),   32'(m_gnt));
         chk("alu_start", 32'(alu_start),      32'(m_start));
         chk("busy",      32'(busy),           32'(m_busy));
         chk("done",      32'({done1, done0}), 32'(m_done));
         chk("err",       32'({err1, err0}),   32'(m_err));
         chk("res0",      32'(res0),           32'(m_res[0]));
         chk("rem0",      32'(rem0),           32'(m_rem[0]));
         chk("res1",      32'(res1),           32'(m_res[1]));
         chk("rem1",      32'(rem1),           32'(m_rem[1]));
         chk("alu_op",    32'(alu_op),         32'(m_op));
         chk("alu_a",     32'(alu_a),          32'(m_a));
         chk("alu_b",     32'(alu_b),          32'(m_b));
      end
   end

   function automatic logic sig_sel(input int sel);
      case (sel)
         0: return gnt0;
         1: return gnt1;
         2: return done0;
         3: return done1;
         default: return gnt0 | gnt1;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int budget, input string nm, output int n);
      logic hit;
      hit = 1'b0;
      n = 0;
      while (!hit && n < budget) begin
         @(negedge clk);
         #1;
         n++;
         hit = sig_sel(sel);
      end
      chk({nm, "_seen"}, 32'(hit), 32'd1);
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      chk("rst_flags", 32'({gnt0, gnt1, done0, done1, err0, err1, alu_start, busy}), 32'd0);
      chk("rst_res",   32'({res0, res1}), 32'd0);
      chk("rst_rem",   32'({rem0, rem1}), 32'd0);
      chk("rst_alu",   32'({alu_op, alu_a, alu_b}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic rnd_ops(output logic [OW-1:0] op, output logic [DW-1:0] a, output logic [DW-1:0] b);
      op = OW'($urandom);
      a  = DW'($urandom);
      b  = ($urandom_range(0, 9) == 0) ? '0 : DW'($urandom);
   endtask

   initial begin
      int n, s0, g0, prev, port;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; op0 = '0; op1 = '0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0; stray = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_res0", 32'(res0), 32'd0);

      // Single multiply on port 0, ALU latency 4.
      alu_lat = 4;
      @(negedge clk);
      op0 = 2'b00; a0 = 16'd58; b0 = 16'd50; req0 = 1'b1;
      @(negedge clk);
      #1;
      chk("t1_gnt0", 32'(gnt0), 32'd1);
      chk("t1_alu_a", 32'(alu_a), 32'd58);
      chk("t1_alu_b", 32'(alu_b), 32'd50);
      req0 = 1'b0;
      wait_for(2, 20, "t1_done0", n);
      chk("t1_res0", 32'(res0), 32'h0B54);
      chk("t1_rem0", 32'(rem0), 32'd0);
      chk("t1_err0", 32'(err0), 32'd0);
      chk("t1_port1", 32'({done1, err1, res1, rem1}), 32'd0);

      // Tie after reset: port 0 first, then port 1 with no request gap.
      reset_pulse();
      s0 = n_start;
      @(negedge clk);
      op0 = 2'b01; a0 = 16'd369; b0 = 16'd58; req0 = 1'b1;
      op1 = 2'b10; a1 = 16'd7744; b1 = 16'd0; req1 = 1'b1;
      wait_for(4, 5, "t2_first_gnt", n);
      chk("t2_first_is_p0", 32'({gnt1, gnt0}), 32'b01);
      req0 = 1'b0;
      wait_for(2, 20, "t2_done0", n);
      chk("t2_res0", 32'(res0), 32'd6);
      chk("t2_rem0", 32'(rem0), 32'd21);
      wait_for(1, 10, "t2_gnt1", n);
      req1 = 1'b0;
      wait_for(3, 20, "t2_done1", n);
      chk("t2_res1", 32'(res1), 32'd88);
      repeat (3) @(negedge clk);
      chk("t2_starts", 32'(n_start - s0), 32'd2);

      // Both requests held: grants must alternate, port 0 first.
      alu_lat = 2;
      rnd_ops(op0, a0, b0);
      rnd_ops(op1, a1, b1);
      req0 = 1'b1; req1 = 1'b1;
      prev = 1;
      for (int i = 0; i < 6; i++) begin
         wait_for(4, 30, "t3_gnt", n);
         port = gnt1 ? 1 : 0;
         chk("t3_alternate", 32'(port), 32'(1 - prev));
         prev = port;
         if (port == 1) rnd_ops(op1, a1, b1); else rnd_ops(op0, a0, b0);
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (20) @(negedge clk);

      // ALU never answers: timeout on port 1, then a stray done.
      alu_lat = -1;
      op1 = 2'b11; a1 = 16'h1234; b1 = 16'h0042; req1 = 1'b1;
      wait_for(1, 5, "t4_gnt1", n);
      req1 = 1'b0;
      wait_for(3, 40, "t4_done1", n);
      chk("t4_timeout_lat", 32'(n), 32'(TMO + 2));
      chk("t4_err1", 32'(err1), 32'd1);
      chk("t4_res1", 32'(res1), 32'd0);
      chk("t4_rem1", 32'(rem1), 32'd0);
      repeat (2) @(negedge clk);
      @(negedge clk);
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk("t4_stray_done", 32'({done1, done0}), 32'd0);
         chk("t4_stray_busy", 32'(busy), 32'd0);
         chk("t4_stray_err1", 32'(err1), 32'd1);
      end

      // Reset while waiting, then a fresh request on port 1.
      op1 = 2'b00; a1 = 16'd9; b1 = 16'd9; req1 = 1'b1;
      wait_for(1, 5, "t5_gnt1", n);
      req1 = 1'b0;
      repeat (3) @(negedge clk);
      reset_pulse();
      alu_lat = 2;
      @(negedge clk);
      op1 = 2'b10; a1 = 16'd7744; b1 = 16'd0; req1 = 1'b1;
      wait_for(1, 5, "t5_gnt1_after", n);
      req1 = 1'b0;
      wait_for(3, 20, "t5_done1", n);
      chk("t5_res1", 32'(res1), 32'd88);
      chk("t5_err1", 32'(err1), 32'd0);

      // Short port-0 request while port 1 is waiting is withdrawn cleanly.
      alu_lat = 8;
      @(negedge clk);
      op1 = 2'b00; a1 = 16'd3; b1 = 16'd5; req1 = 1'b1;
      wait_for(1, 5, "t6_gnt1", n);
      req1 = 1'b0;
      s0 = n_start;
      g0 = n_gnt0;
      repeat (2) @(negedge clk);
      op0 = 2'b01; a0 = 16'd100; b0 = 16'd7; req0 = 1'b1;
      @(negedge clk);
      req0 = 1'b0;
      wait_for(3, 20, "t6_done1", n);
      chk("t6_res1", 32'(res1), 32'd15);
      repeat (5) @(negedge clk);
      chk("t6_no_gnt0", 32'(n_gnt0 - g0), 32'd0);
      chk("t6_no_start", 32'(n_start - s0), 32'd0);

      // Random traffic with random ALU latency including timeouts.
      alu_lat = 0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         #1;
         if (req0 && gnt0) begin
            if ($urandom_range(0, 2) == 0) req0 = 1'b0; else rnd_ops(op0, a0, b0);
         end else if (req0 && $urandom_range(0, 29) == 0) begin
            req0 = 1'b0;
         end else if (!req0 && $urandom_range(0, 3) == 0) begin
            rnd_ops(op0, a0, b0);
            req0 = 1'b1;
         end
         if (req1 && gnt1) begin
            if ($urandom_range(0, 2) == 0) req1 = 1'b0; else rnd_ops(op1, a1, b1);
         end else if (req1 && $urandom_range(0, 29) == 0) begin
            req1 = 1'b0;
         end else if (!req1 && $urandom_range(0, 3) == 0) begin
            rnd_ops(op1, a1, b1);
            req1 = 1'b1;
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (40) @(negedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
